// File: rtl/zmc2_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : zmc2_fetch_seq
// Purpose  : Fetch controller and load sequencer for the ZMC2 dot shifter.
//            A sprite-line tile request is held in a one-entry slot. Two
//            32-bit C-ROM words are fetched per 16-pixel tile, in display
//            order, over a REQ/ACK handshake. The words are buffered in a
//            small FIFO. A 4-phase sequencer on the pixel-clock enable
//            presents one word per 4 enables on CR with a LOAD strobe.
//
// Ports    : CLK, nRESET        clock, asynchronous active-low reset
//            CLK_EN_12M_N       pixel-clock enable for the sequencer
//            LINE_START         one-CLK flush pulse for a new line
//            TILE_*             tile request handshake and attributes
//            ROM_*              C-ROM word read handshake
//            CR/LOAD/H/EVEN     shifter word, load strobe, direction, parity
//            BUSY               any tile, fetch or buffered word outstanding
//            UNDERRUN           sticky starvation flag, cleared by LINE_START
//
// Config   : ZMC2_FETCH_DEEP_FIFO_EN defined -> 4-entry word FIFO, so a whole
//            tile can be fetched ahead. Undefined -> 2-entry FIFO.
//
// Revision : 1.0  initial release
// ============================================================================
module zmc2_fetch_seq #(
  parameter int ADDR_W = 20,
`ifdef ZMC2_FETCH_DEEP_FIFO_EN
  parameter int FIFO_DEPTH = 4
`else
  parameter int FIFO_DEPTH = 2
`endif
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              CLK_EN_12M_N,
  input  logic              LINE_START,
  input  logic              TILE_VALID,
  output logic              TILE_READY,
  input  logic [ADDR_W-1:0] TILE_ADDR,
  input  logic              TILE_HFLIP,
  input  logic              TILE_XODD,
  output logic              ROM_REQ,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic              ROM_ACK,
  input  logic [31:0]       ROM_DATA,
  output logic [31:0]       CR,
  output logic              LOAD,
  output logic              H,
  output logic              EVEN,
  output logic              BUSY,
  output logic              UNDERRUN
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_W0    = 3'd1,
    F_W1W   = 3'd2,
    F_W1    = 3'd3,
    F_DRAIN = 3'd4
  } fetch_t;

  typedef enum logic {
    S_STOP = 1'b0,
    S_RUN  = 1'b1
  } seq_t;

  // --------------------------------------------------------------------------
  // Tile slot
  // --------------------------------------------------------------------------
  logic              slot_full;
  logic [ADDR_W-1:0] slot_addr;
  logic              slot_hflip;
  logic              slot_xodd;
  logic              slot_free;

  assign TILE_READY = ~slot_full & ~LINE_START;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      slot_full  <= 1'b0;
      slot_addr  <= '0;
      slot_hflip <= 1'b0;
      slot_xodd  <= 1'b0;
    end else if (LINE_START) begin
      slot_full <= 1'b0;
    end else if (slot_free) begin
      slot_full <= 1'b0;
    end else if (TILE_VALID && TILE_READY) begin
      slot_full  <= 1'b1;
      slot_addr  <= TILE_ADDR;
      slot_hflip <= TILE_HFLIP;
      slot_xodd  <= TILE_XODD;
    end
  end

  // Display order: a flipped tile shows its right-hand word first.
  logic [ADDR_W-1:0] addr_left;
  logic [ADDR_W-1:0] addr_right;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] second_addr;

  assign addr_left   = slot_addr;
  assign addr_right  = slot_addr + ADDR_W'(1);
  assign first_addr  = slot_hflip ? addr_right : addr_left;
  assign second_addr = slot_hflip ? addr_left  : addr_right;

  // --------------------------------------------------------------------------
  // Word FIFO: {data, hflip, xodd}
  // --------------------------------------------------------------------------
  logic [33:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_room;
  logic [CNT_W-1:0] cnt_after_push;
  logic [33:0]      head;

  assign fifo_empty     = (fifo_cnt == '0);
  assign fifo_room      = (fifo_cnt != CNT_FULL);
  assign cnt_after_push = fifo_cnt + CNT_ONE - (pop ? CNT_ONE : '0);
  assign head           = fifo_mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (LINE_START) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {ROM_DATA, slot_hflip, slot_xodd};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    end
  end

  // --------------------------------------------------------------------------
  // Fetcher FSM
  // --------------------------------------------------------------------------
  fetch_t            fetch_q;
  fetch_t            fetch_nxt;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_nxt;

  assign ROM_REQ  = (fetch_q == F_W0) || (fetch_q == F_W1) || (fetch_q == F_DRAIN);
  assign ROM_ADDR = rom_addr_q;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      fetch_q    <= F_IDLE;
      rom_addr_q <= '0;
    end else begin
      fetch_q    <= fetch_nxt;
      rom_addr_q <= rom_addr_nxt;
    end
  end

  always_comb begin
    fetch_nxt    = fetch_q;
    rom_addr_nxt = rom_addr_q;
    push         = 1'b0;
    slot_free    = 1'b0;
    unique case (fetch_q)
      F_IDLE: begin
        if (!LINE_START && slot_full && fifo_room) begin
          fetch_nxt    = F_W0;
          rom_addr_nxt = first_addr;
        end
      end
      F_W0: begin
        if (LINE_START) begin
          // A request in flight must still be completed by the arbiter.
          fetch_nxt = ROM_ACK ? F_IDLE : F_DRAIN;
        end else if (ROM_ACK) begin
          push = 1'b1;
          if (cnt_after_push == CNT_FULL) begin
            fetch_nxt = F_W1W;
          end else begin
            fetch_nxt    = F_W1;
            rom_addr_nxt = second_addr;
          end
        end
      end
      F_W1W: begin
        if (LINE_START) begin
          fetch_nxt = F_IDLE;
        end else if (fifo_room) begin
          fetch_nxt    = F_W1;
          rom_addr_nxt = second_addr;
        end
      end
      F_W1: begin
        if (LINE_START) begin
          fetch_nxt = ROM_ACK ? F_IDLE : F_DRAIN;
        end else if (ROM_ACK) begin
          push      = 1'b1;
          slot_free = 1'b1;
          fetch_nxt = F_IDLE;
        end
      end
      F_DRAIN: begin
        if (ROM_ACK) fetch_nxt = F_IDLE;
      end
      default: fetch_nxt = F_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load sequencer
  // --------------------------------------------------------------------------
  seq_t        seq_q;
  seq_t        seq_nxt;
  logic [1:0]  phase_q;
  logic [1:0]  phase_nxt;
  logic [31:0] cr_q;
  logic [31:0] cr_nxt;
  logic        load_q;
  logic        load_nxt;
  logic        h_q;
  logic        h_nxt;
  logic        even_q;
  logic        even_nxt;
  logic        underrun_q;
  logic        underrun_nxt;
  logic        supply_pending;

  // A word is still on its way: starving now is an underrun, not end of line.
  assign supply_pending = slot_full || (fetch_q != F_IDLE);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      seq_q      <= S_STOP;
      phase_q    <= 2'd0;
      cr_q       <= '0;
      load_q     <= 1'b0;
      h_q        <= 1'b1;
      even_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      seq_q      <= seq_nxt;
      phase_q    <= phase_nxt;
      cr_q       <= cr_nxt;
      load_q     <= load_nxt;
      h_q        <= h_nxt;
      even_q     <= even_nxt;
      underrun_q <= underrun_nxt;
    end
  end

  always_comb begin
    seq_nxt      = seq_q;
    phase_nxt    = phase_q;
    cr_nxt       = cr_q;
    load_nxt     = load_q;
    h_nxt        = h_q;
    even_nxt     = even_q;
    underrun_nxt = underrun_q;
    pop          = 1'b0;
    if (LINE_START) begin
      seq_nxt      = S_STOP;
      phase_nxt    = 2'd0;
      load_nxt     = 1'b0;
      cr_nxt       = '0;
      underrun_nxt = 1'b0;
    end else if (CLK_EN_12M_N) begin
      unique case (seq_q)
        S_STOP: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            cr_nxt    = head[33:2];
            h_nxt     = ~head[1];
            even_nxt  = head[0];
            load_nxt  = 1'b1;
            phase_nxt = 2'd1;
            seq_nxt   = S_RUN;
          end
        end
        S_RUN: begin
          if (phase_q != 2'd0) begin
            load_nxt  = 1'b0;
            phase_nxt = phase_q + 2'd1;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            cr_nxt    = head[33:2];
            h_nxt     = ~head[1];
            even_nxt  = head[0];
            load_nxt  = 1'b1;
            phase_nxt = 2'd1;
          end else if (supply_pending) begin
            // Load a transparent word to keep the shifter cadence intact.
            underrun_nxt = 1'b1;
            cr_nxt       = '0;
            load_nxt     = 1'b1;
            phase_nxt    = 2'd1;
          end else begin
            load_nxt = 1'b0;
            seq_nxt  = S_STOP;
          end
        end
        default: seq_nxt = S_STOP;
      endcase
    end
  end

  assign CR       = cr_q;
  assign LOAD     = load_q;
  assign H        = h_q;
  assign EVEN     = even_q;
  assign UNDERRUN = underrun_q;
  assign BUSY     = slot_full || (fetch_q != F_IDLE) || !fifo_empty || (seq_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_zmc2_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_zmc2_fetch_seq
// Purpose  : Scoreboard bench for zmc2_fetch_seq. Tile issue pushes the
//            expected ROM addresses and shifter words; a ROM responder and a
//            LOAD monitor pop and compare independently.
// Revision : 1.0  initial release
// ============================================================================
module tb_zmc2_fetch_seq;
  localparam int AW = 20;

  typedef struct {
    logic [31:0] data;
    logic        h;
    logic        even;
  } word_t;

  logic          CLK;
  logic          nRESET;
  logic          CLK_EN_12M_N;
  logic          LINE_START;
  logic          TILE_VALID;
  logic          TILE_READY;
  logic [AW-1:0] TILE_ADDR;
  logic          TILE_HFLIP;
  logic          TILE_XODD;
  logic          ROM_REQ;
  logic [AW-1:0] ROM_ADDR;
  logic          ROM_ACK;
  logic [31:0]   ROM_DATA;
  logic [31:0]   CR;
  logic          LOAD;
  logic          H;
  logic          EVEN;
  logic          BUSY;
  logic          UNDERRUN;

  zmc2_fetch_seq #(.ADDR_W(AW)) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_EN_12M_N(CLK_EN_12M_N),
    .LINE_START(LINE_START), .TILE_VALID(TILE_VALID), .TILE_READY(TILE_READY),
    .TILE_ADDR(TILE_ADDR), .TILE_HFLIP(TILE_HFLIP), .TILE_XODD(TILE_XODD),
    .ROM_REQ(ROM_REQ), .ROM_ADDR(ROM_ADDR), .ROM_ACK(ROM_ACK), .ROM_DATA(ROM_DATA),
    .CR(CR), .LOAD(LOAD), .H(H), .EVEN(EVEN), .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  // Scoreboard and run state
  word_t         exp_word[$];
  logic [AW-1:0] exp_addr[$];
  int            load_ticks[$];
  int vectors = 0, miscompares = 0;
  int tick = 0, en_div = 1, ack_lat = 1, hold_idx = -1, hold_clks = 0;
  int ack_count = 0, load_count = 0, underrun_loads = 0;
  bit allow_underrun = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ROM contents: an arbitrary hash of the address, never zero, so a real
  // word can always be told apart from a transparent underrun load.
  function automatic logic [31:0] rom_func(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {12'h0, a} * 32'h9E37_79B1;
    return x | 32'h1;
  endfunction

  // Pixel-clock enable: one enable every en_div CLKs.
  initial begin
    int ecnt = 0;
    CLK_EN_12M_N = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      ecnt++;
      CLK_EN_12M_N = ((ecnt % en_div) == 0);
    end
  end

  initial forever begin
    @(posedge CLK);
    if (CLK_EN_12M_N) tick++;
  end

  // ROM responder: acknowledges after ack_lat CLKs (hold_clks for ack number
  // hold_idx) and checks each requested address against the scoreboard.
  initial begin
    int lat = 0;
    int target;
    ROM_ACK  = 1'b0;
    ROM_DATA = '0;
    forever begin
      @(negedge CLK);
      ROM_ACK = 1'b0;
      if (!nRESET || !ROM_REQ) begin
        lat = 0;
      end else begin
        target = (ack_count == hold_idx) ? hold_clks : ack_lat;
        if (lat >= target) begin
          if (exp_addr.size() == 0) chk_eq("rom_req_unexpected", ROM_REQ, 0);
          else chk_eq("rom_addr", ROM_ADDR, exp_addr.pop_front());
          ROM_ACK  = 1'b1;
          ROM_DATA = rom_func(ROM_ADDR);
          ack_count++;
          lat = 0;
        end else begin
          lat++;
        end
      end
    end
  end

  // LOAD monitor: one sample per enable, in the cycle the shifter consumes it.
  initial begin
    word_t w;
    forever begin
      @(negedge CLK);
      if (nRESET && CLK_EN_12M_N && LOAD) begin
        load_count++;
        load_ticks.push_back(tick);
        if (CR == 32'h0) begin
          underrun_loads++;
          chk_eq("underrun_load_allowed", allow_underrun, 1);
          chk_eq("underrun_flag", UNDERRUN, 1);
        end else if (exp_word.size() == 0) begin
          chk_eq("unexpected_load_cr", CR, 0);
        end else begin
          w = exp_word.pop_front();
          chk_eq("cr", CR, w.data);
          chk_eq("h", H, w.h);
          chk_eq("even", EVEN, w.even);
        end
      end
    end
  end

  task automatic issue_tile(input logic [AW-1:0] a, input bit hf, input bit xo);
    logic [AW-1:0] left, right, first, second;
    int n;
    word_t w;
    left   = a;
    right  = a + AW'(1);
    first  = hf ? right : left;
    second = hf ? left : right;
    n = 0;
    @(negedge CLK);
    while (!TILE_READY && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (!TILE_READY) begin
      chk_eq("tile_ready_timeout", TILE_READY, 1);
      return;
    end
    exp_addr.push_back(first);
    exp_addr.push_back(second);
    w.h = ~hf;
    w.even = xo;
    w.data = rom_func(first);
    exp_word.push_back(w);
    w.data = rom_func(second);
    exp_word.push_back(w);
    TILE_VALID = 1'b1;
    TILE_ADDR  = a;
    TILE_HFLIP = hf;
    TILE_XODD  = xo;
    @(posedge CLK);
    #1;
    TILE_VALID = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSY && n < 3000);
    t = tick;
    if (BUSY) chk_eq("idle_timeout", BUSY, 0);
  endtask

  task automatic check_spacing(input string name);
    for (int i = 1; i < load_ticks.size(); i++)
      chk_eq(name, load_ticks[i] - load_ticks[i-1], 4);
  endtask

  task automatic check_drained(input string name);
    chk_eq({name, "_words_left"}, exp_word.size(), 0);
    chk_eq({name, "_addrs_left"}, exp_addr.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    chk_eq(name, {ROM_REQ, ROM_ADDR, CR, LOAD, H, EVEN, UNDERRUN, BUSY, TILE_READY},
           {1'b0, 20'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    int t;
    int n;
    int lc;
    nRESET = 1'b0;
    LINE_START = 1'b0;
    TILE_VALID = 1'b0;
    TILE_ADDR = '0;
    TILE_HFLIP = 1'b0;
    TILE_XODD = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset_state");
    nRESET = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_vals("post_reset_state");

    // 1: plain tile, ack after 1 CLK
    en_div = 1; ack_lat = 1;
    load_ticks.delete();
    issue_tile(20'h00100, 1'b0, 1'b0);
    wait_idle(t);
    chk_eq("t1_load_count", load_ticks.size(), 2);
    if (load_ticks.size() > 0) chk_eq("t1_stop_tick", t, load_ticks[0] + 8);
    check_spacing("t1_spacing");
    check_drained("t1");
    chk_eq("t1_load_low", LOAD, 0);

    // 2: flipped, odd tile at the top of the address space
    load_ticks.delete();
    issue_tile(20'hFFFFF, 1'b1, 1'b1);
    wait_idle(t);
    chk_eq("t2_load_count", load_ticks.size(), 2);
    if (load_ticks.size() > 0) chk_eq("t2_stop_tick", t, load_ticks[0] + 8);
    check_drained("t2");

    // 3: three back-to-back tiles, 2-CLK ack latency, enable every 2 CLKs
    en_div = 2; ack_lat = 2;
    load_ticks.delete();
    for (int i = 0; i < 3; i++)
      issue_tile(AW'($urandom), 1'($urandom), 1'($urandom));
    wait_idle(t);
    chk_eq("t3_load_count", load_ticks.size(), 6);
    check_spacing("t3_spacing");
    chk_eq("t3_underrun", UNDERRUN, 0);
    check_drained("t3");

    // 4: second word held 20 enables -> transparent loads, sticky flag
    en_div = 1; ack_lat = 1;
    allow_underrun = 1'b1;
    underrun_loads = 0;
    hold_idx = ack_count + 1;
    hold_clks = 20;
    load_ticks.delete();
    issue_tile(AW'($urandom), 1'($urandom), 1'($urandom));
    wait_idle(t);
    chk_eq("t4_underrun_loads_ge3", underrun_loads >= 3, 1);
    check_spacing("t4_spacing");
    check_drained("t4");
    repeat (10) @(negedge CLK);
    chk_eq("t4_underrun_sticky", UNDERRUN, 1);
    allow_underrun = 1'b0;
    hold_idx = -1;

    // 5: LINE_START during an outstanding request, with a tile offered
    hold_idx = ack_count;
    hold_clks = 12;
    issue_tile(AW'($urandom), 1'($urandom), 1'($urandom));
    n = 0;
    while (!ROM_REQ && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk_eq("t5_req_seen", ROM_REQ, 1);
    exp_word.delete();
    while (exp_addr.size() > 1) void'(exp_addr.pop_back());
    LINE_START = 1'b1;
    TILE_VALID = 1'b1;
    TILE_ADDR  = AW'($urandom);
    @(posedge CLK);
    #1;
    LINE_START = 1'b0;
    TILE_VALID = 1'b0;
    @(negedge CLK);
    chk_eq("t5_after_flush", {TILE_READY, ROM_REQ, LOAD, UNDERRUN, BUSY, CR},
           {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    wait_idle(t);
    repeat (30) @(negedge CLK);
    chk_eq("t5_quiet", {ROM_REQ, BUSY, LOAD, UNDERRUN}, 4'b0000);
    check_drained("t5");
    hold_idx = -1;

    // 6: reset asserted in the middle of a word
    issue_tile(AW'($urandom), 1'b1, 1'b1);
    lc = load_count;
    n = 0;
    while (load_count == lc && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk_eq("t6_first_load", load_count > lc, 1);
    @(negedge CLK);
    chk_eq("t6_h_before_reset", H, 0);
    #2;
    nRESET = 1'b0;
    #1;
    check_reset_vals("t6_async_reset");
    exp_word.delete();
    exp_addr.delete();
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    check_reset_vals("t6_after_release");

    // 7: randomized tile stream
    en_div = 2;
    load_ticks.delete();
    for (int i = 0; i < 5; i++) begin
      ack_lat = $urandom_range(0, 2);
      issue_tile(AW'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle(t);
    chk_eq("t7_load_count", load_ticks.size(), 10);
    check_spacing("t7_spacing");
    chk_eq("t7_underrun", UNDERRUN, 0);
    check_drained("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
